// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - round-robin arbiter sharing one memory port between I-cache and D-cache
//
// Purpose:
//   Grants one block transaction at a time to either the instruction cache
//   (read only) or the data cache (read or write-back). Command outputs are
//   registered and held until the memory answers with mem_ready; the owner then
//   receives a one-cycle ready pulse and, on reads, the returned block.
//   Transaction shape: IDLE (grant) -> BUSY_I/BUSY_D (wait mem_ready) -> DONE -> IDLE.
//
// Optional feature (macro ARB_PERF_CNT_EN):
//   Adds grant_i_cnt, grant_d_cnt and a saturating wait_cnt as output ports.
//
// Ports:
//   clk, rst                  clock; asynchronous active-low reset
//   i_read, i_addr            I-cache block read request (level) and address
//   i_rdata, i_ready          block returned to I-cache, one-cycle completion pulse
//   d_read, d_write, d_addr   D-cache read / write-back request (level) and address
//   d_wdata                   D-cache write-back data
//   d_rdata, d_ready          block returned to D-cache, one-cycle completion pulse
//   mem_read, mem_write       memory command, held until mem_ready
//   mem_addr, mem_wdata       memory block address and write data
//   mem_rdata, mem_ready      memory read data and completion
//   grant_i_cnt, grant_d_cnt, wait_cnt   performance counters (ARB_PERF_CNT_EN only)

module mem_bus_arbiter #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ready,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0]       grant_i_cnt,
  output logic [31:0]       grant_d_cnt,
  output logic [31:0]       wait_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, DONE} state_t;

  state_t              state_q, state_d;
  logic                rr_q, rr_d;          // 0: D wins a tie, 1: I wins a tie
  logic                mem_read_q, mem_read_d;
  logic                mem_write_q, mem_write_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                i_ready_q, i_ready_d;
  logic                d_ready_q, d_ready_d;
  logic [DATA_W-1:0]   i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
  logic                grant_i, grant_d;
  logic                d_req;

  assign d_req = d_read | d_write;

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    i_ready_d   = 1'b0;
    d_ready_d   = 1'b0;
    grant_i     = 1'b0;
    grant_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (d_req && (!i_read || !rr_q)) begin
          grant_d = 1'b1;
        end else if (i_read) begin
          grant_i = 1'b1;
        end

        if (grant_d) begin
          // A simultaneous read+write from the D-cache is a write-back.
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
          mem_write_d = d_write;
          mem_read_d  = ~d_write;
          rr_d        = 1'b1;
          state_d     = BUSY_D;
        end else if (grant_i) begin
          mem_addr_d  = i_addr;
          mem_read_d  = 1'b1;
          mem_write_d = 1'b0;
          rr_d        = 1'b0;
          state_d     = BUSY_I;
        end
      end

      BUSY_I: begin
        if (mem_ready) begin
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          i_ready_d   = 1'b1;
          i_rdata_d   = mem_rdata;
          state_d     = DONE;
        end
      end

      BUSY_D: begin
        if (mem_ready) begin
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          d_ready_d   = 1'b1;
          if (mem_read_q) begin
            d_rdata_d = mem_rdata;
          end
          state_d     = DONE;
        end
      end

      // Dead cycle lets the owner drop its level request before re-arbitration.
      DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      rr_q        <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_ready_q   <= 1'b0;
      d_ready_q   <= 1'b0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      i_ready_q   <= i_ready_d;
      d_ready_q   <= d_ready_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign i_ready   = i_ready_q;
  assign d_ready   = d_ready_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;

`ifdef ARB_PERF_CNT_EN
  logic [31:0] grant_i_cnt_q, grant_d_cnt_q, wait_cnt_q;
  logic        i_wait, d_wait;
  logic [1:0]  wait_inc;
  logic [32:0] wait_sum;

  // A requester is being served while it owns BUSY or is in its DONE cycle
  // (its ready pulse is high exactly then) or is granted this cycle.
  assign i_wait   = i_read && !grant_i && (state_q != BUSY_I) && !((state_q == DONE) && i_ready_q);
  assign d_wait   = d_req  && !grant_d && (state_q != BUSY_D) && !((state_q == DONE) && d_ready_q);
  assign wait_inc = {1'b0, i_wait} + {1'b0, d_wait};
  assign wait_sum = {1'b0, wait_cnt_q} + {31'b0, wait_inc};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant_i_cnt_q <= '0;
      grant_d_cnt_q <= '0;
      wait_cnt_q    <= '0;
    end else begin
      if (grant_i) grant_i_cnt_q <= grant_i_cnt_q + 32'd1;
      if (grant_d) grant_d_cnt_q <= grant_d_cnt_q + 32'd1;
      wait_cnt_q <= wait_sum[32] ? 32'hFFFF_FFFF : wait_sum[31:0];
    end
  end

  assign grant_i_cnt = grant_i_cnt_q;
  assign grant_d_cnt = grant_d_cnt_q;
  assign wait_cnt    = wait_cnt_q;
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - self-checking bench for mem_bus_arbiter with a completion scoreboard
module tb_mem_bus_arbiter;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_read;
  logic [27:0]   i_addr;
  logic [127:0]  i_rdata;
  logic          i_ready;
  logic          d_read;
  logic          d_write;
  logic [27:0]   d_addr;
  logic [127:0]  d_wdata;
  logic [127:0]  d_rdata;
  logic          d_ready;
  logic          mem_read;
  logic          mem_write;
  logic [27:0]   mem_addr;
  logic [127:0]  mem_wdata;
  logic [127:0]  mem_rdata;
  logic          mem_ready;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic         who;   // 0: I-cache, 1: D-cache
    logic [127:0] data;  // expected owner rdata at the ready pulse
  } exp_t;

  exp_t         sb[$];
  logic [127:0] model_i, model_d;   // expected rdata as completions are queued
  logic [127:0] last_i, last_d;     // rdata of each side after its last completion

  mem_bus_arbiter #(.ADDR_W(28), .DATA_W(128)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait for the arbiter to issue a command, then check it; n = edges waited.
  task automatic wait_cmd(input logic exp_w, input logic [27:0] a, input logic [127:0] wd,
                          output int n);
    n = 0;
    while (!(mem_read || mem_write) && n < 40) begin
      tick();
      n++;
    end
    chk("cmd_seen", 128'(mem_read | mem_write), 128'(1'b1));
    chk("cmd_write", 128'(mem_write), 128'(exp_w));
    chk("cmd_read", 128'(mem_read), 128'(!exp_w));
    chk("cmd_addr", 128'(mem_addr), 128'(a));
    if (exp_w) chk("cmd_wdata", mem_wdata, wd);
  endtask

  task automatic hold(input int cycles, input logic exp_w, input logic [27:0] a);
    for (int k = 0; k < cycles; k++) begin
      tick();
      chk("hold_op", 128'({mem_read, mem_write}), 128'({!exp_w, exp_w}));
      chk("hold_addr", 128'(mem_addr), 128'(a));
    end
  endtask

  // Memory answers; mem_ready optionally stays high for one more edge.
  task automatic finish(input logic [127:0] data, input logic keep);
    mem_rdata = data;
    mem_ready = 1'b1;
    tick();
    chk("cmd_dropped", 128'({mem_read, mem_write}), 128'(2'b00));
    if (keep) tick();
    mem_ready = 1'b0;
    mem_rdata = {4{$urandom}};
  endtask

  task automatic push_i(input logic [127:0] data);
    model_i = data;
    sb.push_back('{who: 1'b0, data: data});
  endtask

  task automatic push_d(input logic is_write, input logic [127:0] data);
    if (!is_write) model_d = data;
    sb.push_back('{who: 1'b1, data: model_d});
  endtask

  task automatic do_reset();
    rst = 1'b0;
    model_i = '0; model_d = '0; last_i = '0; last_d = '0;
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask

  // Completion monitor: pops the scoreboard on every ready pulse.
  always @(negedge clk) begin
    if (rst) begin
      chk("excl_ready", 128'(i_ready & d_ready), 128'(1'b0));
      chk("excl_cmd", 128'(mem_read & mem_write), 128'(1'b0));
      if (i_ready || d_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_ready", 128'({i_ready, d_ready}), 128'(2'b00));
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("ready_owner", 128'(d_ready), 128'(e.who));
          if (e.who) begin
            chk("d_rdata", d_rdata, e.data);
            chk("i_rdata_hold", i_rdata, last_i);
            last_d = e.data;
          end else begin
            chk("i_rdata", i_rdata, e.data);
            chk("d_rdata_hold", d_rdata, last_d);
            last_i = e.data;
          end
        end
      end
    end
  end

  initial begin
    int n;
    logic [127:0] dd, id;
    rst = 1'b0;
    i_read = 0; i_addr = '0; d_read = 0; d_write = 0; d_addr = '0; d_wdata = '0;
    mem_rdata = '0; mem_ready = 0;
    model_i = '0; model_d = '0; last_i = '0; last_d = '0;

    // Reset state
    tick();
    tick();
    chk("rst_cmd", 128'({mem_read, mem_write}), 128'(2'b00));
    chk("rst_addr", 128'(mem_addr), 128'(0));
    chk("rst_wdata", mem_wdata, 128'(0));
    chk("rst_ready", 128'({i_ready, d_ready}), 128'(2'b00));
    chk("rst_i_rdata", i_rdata, 128'(0));
    chk("rst_d_rdata", d_rdata, 128'(0));
    rst = 1'b1;
    tick();

    // I-only read, memory latency 4
    i_read = 1; i_addr = 28'h0000010;
    push_i(128'h1111_2222_3333_4444);
    wait_cmd(1'b0, 28'h10, '0, n);
    chk("i_grant_lat", 128'(n), 128'(1));
    hold(3, 1'b0, 28'h10);
    finish(128'h1111_2222_3333_4444, 1'b0);
    chk("i_ready_pulse", 128'({i_ready, d_ready}), 128'(2'b10));
    chk("i_rdata_now", i_rdata, 128'h1111_2222_3333_4444);
    i_read = 0;
    tick();
    chk("i_ready_one_cycle", 128'(i_ready), 128'(0));
    tick();

    // Simultaneous requests after reset: D, then I, three times
    do_reset();
    for (int p = 0; p < 3; p++) begin
      dd = {4{32'hD000_0000 + 32'(p)}};
      id = {4{32'h1000_0000 + 32'(p)}};
      d_addr = 28'h100 + 28'(p); i_addr = 28'h200 + 28'(p);
      d_read = 1; i_read = 1;
      push_d(1'b0, dd);
      push_i(id);
      wait_cmd(1'b0, 28'h100 + 28'(p), '0, n);
      hold(1, 1'b0, 28'h100 + 28'(p));
      finish(dd, 1'b0);
      d_read = 0;
      wait_cmd(1'b0, 28'h200 + 28'(p), '0, n);
      chk("rearb_lat", 128'(n), 128'(2));
      hold(2, 1'b0, 28'h200 + 28'(p));
      finish(id, 1'b0);
      i_read = 0;
      tick();
    end

    // D write-back; d_rdata must keep the last read block
    d_write = 1; d_addr = 28'h20; d_wdata = 128'hDEAD_BEEF_0000_0932;
    push_d(1'b1, '0);
    wait_cmd(1'b1, 28'h20, 128'hDEAD_BEEF_0000_0932, n);
    hold(2, 1'b1, 28'h20);
    finish(128'hBAD0_BAD0_BAD0_BAD0, 1'b0);
    d_write = 0;
    tick();

    // d_read and d_write together is a write
    d_read = 1; d_write = 1; d_addr = 28'h24; d_wdata = 128'h0123_4567_89AB_CDEF;
    push_d(1'b1, '0);
    wait_cmd(1'b1, 28'h24, 128'h0123_4567_89AB_CDEF, n);
    finish(128'hBAD1_BAD1_BAD1_BAD1, 1'b0);
    d_read = 0; d_write = 0;
    tick();

    // I drops its request mid-BUSY; mem_ready held across two edges
    i_read = 1; i_addr = 28'h30;
    push_i(128'hCAFE_0000_FACE_0001);
    wait_cmd(1'b0, 28'h30, '0, n);
    tick();
    i_read = 0;
    hold(2, 1'b0, 28'h30);
    finish(128'hCAFE_0000_FACE_0001, 1'b1);
    tick();

    // Stray mem_ready while IDLE
    mem_ready = 1; mem_rdata = 128'h5555;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stray_ready", 128'({i_ready, d_ready}), 128'(2'b00));
      chk("stray_cmd", 128'({mem_read, mem_write}), 128'(2'b00));
    end
    mem_ready = 0;
    tick();

    // Reset mid-transaction while BUSY_D
    d_write = 1; d_addr = 28'h30; d_wdata = 128'h7777_8888;
    wait_cmd(1'b1, 28'h30, 128'h7777_8888, n);
    tick();
    rst = 0;
    d_write = 0;
    #1;
    chk("midrst_cmd", 128'({mem_read, mem_write}), 128'(2'b00));
    chk("midrst_addr", 128'(mem_addr), 128'(0));
    chk("midrst_wdata", mem_wdata, 128'(0));
    model_i = '0; model_d = '0; last_i = '0; last_d = '0;
    tick();
    rst = 1;
    tick();
    i_read = 1; i_addr = 28'h40;
    push_i(128'h4040_4040);
    wait_cmd(1'b0, 28'h40, '0, n);
    chk("post_rst_lat", 128'(n), 128'(1));
    finish(128'h4040_4040, 1'b0);
    i_read = 0;
    tick();
    tick();
    tick();

    chk("scoreboard_empty", 128'(sb.size()), 128'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
